// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/execute controller for the 16-bit program counter.
// Drives PC reset/load/increment pulses, runs the instruction fetch handshake with
// a timeout, captures the instruction register and counts retired instructions.
// Optional halt-loop detection is compiled in with `define PC_SEQ_HALT_DETECT_EN.
module pc_sequencer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_mem_ack,
  input  logic [DATA_W-1:0]  i_instr_in,
  input  logic [DATA_W-1:0]  i_a_reg,
  input  logic [DATA_W-1:0]  i_pc_value,
  input  logic               i_zr,
  input  logic               i_ng,
  output logic               o_mem_req,
  output logic               o_pc_reset,
  output logic               o_pc_load,
  output logic               o_pc_inc,
  output logic [DATA_W-1:0]  o_pc_d_in,
  output logic [DATA_W-1:0]  o_ir,
  output logic               o_busy,
  output logic               o_fetch_err,
  output logic               o_halted,
  output logic [COUNT_W-1:0] o_instr_count
);

  localparam int unsigned TCNT_W = 8;

`ifdef PC_SEQ_HALT_DETECT_EN
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_FETCH, S_EXEC} state_t;
`endif

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_ir;
  logic [COUNT_W-1:0]  r_count;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_ferr;

  logic w_mem_req, w_pc_reset, w_pc_load, w_pc_inc, w_busy;
  logic w_ack_take, w_timeout, w_retire, w_start_take, w_tcnt_inc;
  logic w_jump;

  // Jump condition from instruction bits and ALU flags (C-instructions only).
  assign w_jump = r_ir[15] & ((r_ir[2] & i_ng) | (r_ir[1] & i_zr) | (r_ir[0] & ~i_ng & ~i_zr));

`ifdef PC_SEQ_HALT_DETECT_EN
  logic r_halted;
  logic w_halt_set;
  logic w_self;
  assign w_self = (i_a_reg == i_pc_value);
`else
  logic w_unused_pc;
  assign w_unused_pc = ^i_pc_value;
`endif

  // Next-state and pulse/strobe decode; reset forces INIT with all outputs low.
  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_pc_reset   = 1'b0;
    w_pc_load    = 1'b0;
    w_pc_inc     = 1'b0;
    w_busy       = 1'b0;
    w_ack_take   = 1'b0;
    w_timeout    = 1'b0;
    w_retire     = 1'b0;
    w_start_take = 1'b0;
    w_tcnt_inc   = 1'b0;
`ifdef PC_SEQ_HALT_DETECT_EN
    w_halt_set   = 1'b0;
`endif
    case (r_state)
      S_INIT: begin
        w_pc_reset = 1'b1;
        w_next     = S_IDLE;
      end
      S_IDLE: begin
        if (i_start) begin
          w_start_take = 1'b1;
          w_next       = S_FETCH;
        end
      end
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_busy    = 1'b1;
        if (i_mem_ack) begin
          w_ack_take = 1'b1;
          w_next     = S_EXEC;
        end else if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_tcnt_inc = 1'b1;
        end
      end
      S_EXEC: begin
        w_busy   = 1'b1;
        w_retire = 1'b1;
        w_pc_load = w_jump;
        w_pc_inc  = ~w_jump;
`ifdef PC_SEQ_HALT_DETECT_EN
        if (w_jump && w_self) begin
          w_halt_set = 1'b1;
          w_next     = S_HALT;
        end else
`endif
        if (i_stop) w_next = S_IDLE;
        else        w_next = S_FETCH;
      end
`ifdef PC_SEQ_HALT_DETECT_EN
      S_HALT: begin
        if (i_start) begin
          w_start_take = 1'b1;
          w_next       = S_FETCH;
        end
      end
`endif
      default: w_next = S_INIT;
    endcase
    if (i_reset) begin
      w_next     = S_INIT;
      w_mem_req  = 1'b0;
      w_pc_reset = 1'b0;
      w_pc_load  = 1'b0;
      w_pc_inc   = 1'b0;
      w_busy     = 1'b0;
    end
  end

  // State, instruction register, counters and sticky flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_INIT;
      r_ir    <= '0;
      r_count <= '0;
      r_tcnt  <= '0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ack_take)   r_ir    <= i_instr_in;
      if (w_retire)     r_count <= r_count + COUNT_W'(1);
      if (w_tcnt_inc)   r_tcnt  <= r_tcnt + TCNT_W'(1);
      else              r_tcnt  <= '0;
      if (w_timeout)    r_ferr  <= 1'b1;
      else if (w_start_take) r_ferr <= 1'b0;
    end
  end

`ifdef PC_SEQ_HALT_DETECT_EN
  // Halt-loop flag: set on jump-to-self, cleared by reset or resume.
  always_ff @(posedge i_clk) begin
    if (i_reset)           r_halted <= 1'b0;
    else if (w_halt_set)   r_halted <= 1'b1;
    else if (w_start_take) r_halted <= 1'b0;
  end
  assign o_halted = r_halted;
`else
  assign o_halted = 1'b0;
`endif

  assign o_mem_req     = w_mem_req;
  assign o_pc_reset    = w_pc_reset;
  assign o_pc_load     = w_pc_load;
  assign o_pc_inc      = w_pc_inc;
  assign o_pc_d_in     = w_pc_load ? i_a_reg : '0;
  assign o_busy        = w_busy;
  assign o_ir          = r_ir;
  assign o_fetch_err   = r_ferr;
  assign o_instr_count = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized fetch/execute
// traffic checked against a transaction-level model of the sequencer.
module tb_pc_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned TO = 15;
  localparam int unsigned CW = 16;

  localparam int ST_IDLE  = 0;
  localparam int ST_FETCH = 1;
  localparam int ST_HALT  = 2;

  logic          clk = 1'b0;
  logic          i_reset, i_start, i_stop, i_mem_ack, i_zr, i_ng;
  logic [DW-1:0] i_instr_in, i_a_reg, i_pc_value;
  logic          o_mem_req, o_pc_reset, o_pc_load, o_pc_inc, o_busy, o_fetch_err, o_halted;
  logic [DW-1:0] o_pc_d_in, o_ir;
  logic [CW-1:0] o_instr_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] m_ir;
  logic [CW-1:0] m_count;
  logic          m_ferr, m_halted;
  int            m_state;

  pc_sequencer #(.DATA_W(DW), .TIMEOUT(TO), .COUNT_W(CW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_mem_ack(i_mem_ack), .i_instr_in(i_instr_in), .i_a_reg(i_a_reg),
    .i_pc_value(i_pc_value), .i_zr(i_zr), .i_ng(i_ng),
    .o_mem_req(o_mem_req), .o_pc_reset(o_pc_reset), .o_pc_load(o_pc_load),
    .o_pc_inc(o_pc_inc), .o_pc_d_in(o_pc_d_in), .o_ir(o_ir), .o_busy(o_busy),
    .o_fetch_err(o_fetch_err), .o_halted(o_halted), .o_instr_count(o_instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs();
    chk("ir", 32'(o_ir), 32'(m_ir));
    chk("instr_count", 32'(o_instr_count), 32'(m_count));
    chk("fetch_err", 32'(o_fetch_err), 32'(m_ferr));
    chk("halted", 32'(o_halted), 32'(m_halted));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"}, 32'(o_mem_req), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_pc_load"}, 32'(o_pc_load), 0);
    chk({tag, "_pc_inc"}, 32'(o_pc_inc), 0);
    chk({tag, "_pc_reset"}, 32'(o_pc_reset), 0);
  endtask

  // Jump decision from the ALU result class (less/equal/greater than zero).
  function automatic logic model_jump(input logic [DW-1:0] ir, input logic zr, input logic ng);
    logic lt, eq, gt;
    if (!ir[15]) return 1'b0;
    lt = ng;
    eq = zr;
    gt = !ng && !zr;
    return (ir[2] && lt) || (ir[1] && eq) || (ir[0] && gt);
  endfunction

  task automatic cyc_begin();
    @(negedge clk);
    i_start   = 1'b0;
    i_stop    = 1'b0;
    i_mem_ack = 1'b0;
  endtask

  task automatic do_start();
    cyc_begin();
    i_start = 1'b1;
    #1;
    chk_quiet("start");
    chk_regs();
    @(posedge clk);
    m_ferr = 1'b0;
    m_halted = 1'b0;
    m_state = ST_FETCH;
  endtask

  task automatic do_fetch(input int delay, input logic [DW-1:0] instr);
    for (int k = 0; k < delay; k++) begin
      cyc_begin();
      i_start    = 1'($urandom);
      i_stop     = 1'($urandom);
      i_instr_in = DW'($urandom);
      #1;
      chk("fetch_mem_req", 32'(o_mem_req), 1);
      chk("fetch_busy", 32'(o_busy), 1);
      chk("fetch_pulses", 32'({o_pc_load, o_pc_inc, o_pc_reset}), 0);
      chk_regs();
    end
    cyc_begin();
    i_mem_ack  = 1'b1;
    i_instr_in = instr;
    #1;
    chk("ack_mem_req", 32'(o_mem_req), 1);
    chk_regs();
    @(posedge clk);
    m_ir = instr;
  endtask

  task automatic do_timeout();
    for (int k = 0; k < int'(TO); k++) begin
      cyc_begin();
      i_instr_in = DW'($urandom);
      #1;
      chk("to_mem_req", 32'(o_mem_req), 1);
      chk_regs();
    end
    @(posedge clk);
    m_ferr = 1'b1;
    m_state = ST_IDLE;
    cyc_begin();
    #1;
    chk_quiet("after_to");
    chk_regs();
  endtask

  task automatic do_exec(input logic zr, input logic ng, input logic [DW-1:0] a,
                         input logic [DW-1:0] pc, input logic stop);
    logic j;
    cyc_begin();
    i_zr = zr; i_ng = ng; i_a_reg = a; i_pc_value = pc; i_stop = stop;
    i_start = 1'($urandom);
    #1;
    j = model_jump(m_ir, zr, ng);
    chk("exec_pc_load", 32'(o_pc_load), 32'(j));
    chk("exec_pc_inc", 32'(o_pc_inc), 32'(!j));
    chk("exec_pc_d_in", 32'(o_pc_d_in), j ? 32'(a) : 0);
    chk("exec_pc_reset", 32'(o_pc_reset), 0);
    chk("exec_busy", 32'(o_busy), 1);
    chk("exec_mem_req", 32'(o_mem_req), 0);
    chk_regs();
    @(posedge clk);
    m_count = m_count + 1'b1;
`ifdef PC_SEQ_HALT_DETECT_EN
    if (j && a == pc) begin
      m_halted = 1'b1;
      m_state = ST_HALT;
    end else
`endif
    m_state = stop ? ST_IDLE : ST_FETCH;
    if (m_state != ST_FETCH) begin
      cyc_begin();
      #1;
      chk_quiet("post_exec");
      chk_regs();
    end
  endtask

  task automatic model_reset();
    m_ir = '0; m_count = '0; m_ferr = 1'b0; m_halted = 1'b0; m_state = ST_IDLE;
  endtask

  task automatic rand_flags(output logic zr, output logic ng);
    int c;
    c = int'($urandom_range(0, 2));
    zr = (c == 1);
    ng = (c == 0);
  endtask

  initial begin
    logic zr, ng;
    logic [DW-1:0] a, pc;
    i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_mem_ack = 1'b0;
    i_zr = 1'b0; i_ng = 1'b0; i_instr_in = '0; i_a_reg = '0; i_pc_value = '0;
    model_reset();

    // Reset, then a single-cycle pc_reset and IDLE.
    @(negedge clk); #1;
    chk("rst_pulses", 32'({o_pc_load, o_pc_inc, o_pc_reset}), 0);
    @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    #1;
    chk("init_pc_reset", 32'(o_pc_reset), 1);
    chk("init_mem_req", 32'(o_mem_req), 0);
    chk_regs();
    cyc_begin(); #1;
    chk_quiet("idle");
    chk_regs();

    // A-instruction fetched after two wait cycles.
    do_start();
    do_fetch(2, 16'h0003);
    do_exec(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0);
    // JEQ taken / not taken.
    do_fetch(0, 16'hE302);
    do_exec(1'b1, 1'b0, 16'd100, 16'd0, 1'b0);
    do_fetch(1, 16'hE302);
    do_exec(1'b0, 1'b0, 16'd100, 16'd0, 1'b0);
    // JMP with stop.
    do_fetch(0, 16'hE307);
    do_exec(1'b0, 1'b0, 16'd42, 16'd0, 1'b1);

    // Fetch timeout, error cleared by restart, ack on the last allowed cycle.
    do_start();
    do_timeout();
    do_start();
    do_fetch(int'(TO) - 1, 16'hE000);
    do_exec(1'b0, 1'b1, 16'd5, 16'd0, 1'b1);

    // Jump-to-self.
    do_start();
    do_fetch(0, 16'hE307);
    do_exec(1'b0, 1'b0, 16'd7, 16'd7, 1'b0);
    if (m_state == ST_HALT) begin
      cyc_begin(); #1;
      chk_quiet("halt_hold");
      chk_regs();
    end

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      if (m_state != ST_FETCH) do_start();
      if ($urandom_range(0, 9) == 0) begin
        do_timeout();
      end else begin
        do_fetch(int'($urandom_range(0, TO - 1)), DW'($urandom));
        rand_flags(zr, ng);
        a  = DW'($urandom);
        pc = ($urandom_range(0, 7) == 0) ? a : DW'($urandom);
        do_exec(zr, ng, a, pc, ($urandom_range(0, 5) == 0));
      end
    end

    // Reset mid-FETCH with mem_req high.
    if (m_state != ST_FETCH) do_start();
    do_fetch(0, 16'hE307);
    do_exec(1'b0, 1'b0, 16'd9, 16'd9, 1'b0);
    if (m_state != ST_FETCH) do_start();
    cyc_begin();
    #1;
    chk("midfetch_mem_req", 32'(o_mem_req), 1);
    i_reset = 1'b1;
    #1;
    chk("rst2_pulses", 32'({o_pc_load, o_pc_inc, o_pc_reset}), 0);
    @(posedge clk);
    model_reset();
    cyc_begin();
    i_reset = 1'b0;
    #1;
    chk("init2_pc_reset", 32'(o_pc_reset), 1);
    chk_regs();
    cyc_begin(); #1;
    chk_quiet("idle2");
    chk_regs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
